// File: rtl/arbitro_decoder_pkg.sv
// Shared types and sizing for the round-robin arbiter with hold timeout.
package arbitro_decoder_pkg;

    localparam int unsigned NUM_REQ      = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned HOLD_W       = 8;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/arbitro_decoder_decoder_binario.sv
// Gated 4-to-16 binary decoder; all-zero output when disabled.
module decoder_binario
    import arbitro_decoder_pkg::*;
(
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_REQ-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_decoder.sv
// Round-robin arbiter over 16 requesters: one grant at a time, bounded by
// MAX_HOLD cycles, with a one-cycle idle gap between grants.
module arbitro_decoder
    import arbitro_decoder_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;

    // First set request at or above ptr, wrapping 15 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && pick_found) begin
                    state_d   = S_GRANT;
                    gnt_idx_d = pick_idx;
                    hold_d    = '0;
                end
            end
            S_GRANT: begin
                // Voluntary release wins over expiry when both happen together.
                if (!req[gnt_idx_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = gnt_idx_q + IDX_W'(1);
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = S_IDLE;
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == S_GRANT);
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

    decoder_binario u_dec (
        .en_i  (gnt_valid),
        .idx_i (gnt_idx_q),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_arbitro_decoder.sv
// Scoreboard bench: a grant-level reference model queues expected grants,
// a monitor rebuilds observed grants from the outputs and compares.
module tb_arbitro_decoder;

    localparam int MAXH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    arbitro_decoder #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start;
        int idx;
        int len;
        bit to;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // reference model state
    bit m_busy = 0;
    int m_holder = 0;
    int m_len = 0;
    int m_ptr = 0;
    int m_start = 0;

    // monitor state
    bit mon_in = 0;
    int mon_start = 0;
    int mon_idx = 0;
    int mon_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant goes to the first requester at or after ptr,
    // lasts until its request drops or MAX_HOLD cycles have been served.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (!m_busy) begin
                if (en && req != 16'h0) begin
                    for (int k = 0; k < 16; k++) begin
                        if (!m_busy && req[(m_ptr + k) % 16]) begin
                            m_busy   = 1;
                            m_holder = (m_ptr + k) % 16;
                        end
                    end
                    m_len   = 1;
                    m_start = cyc;
                end
            end else if (!req[m_holder]) begin
                exp_q.push_back('{m_start, m_holder, m_len, 1'b0});
                m_ptr  = (m_holder + 1) % 16;
                m_busy = 0;
            end else if (m_len == MAXH) begin
                exp_q.push_back('{m_start, m_holder, m_len, 1'b1});
                m_ptr  = (m_holder + 1) % 16;
                m_busy = 0;
            end else begin
                m_len++;
            end
        end
    end

    // Monitor: rebuild each grant from the outputs and score it at release.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_in) begin
                if (gnt_valid) begin
                    mon_len++;
                    check("gnt_idx_stable", 32'(gnt_idx), 32'(mon_idx));
                    check("gnt_onehot", 32'(gnt), 32'(16'h1 << mon_idx));
                end else begin
                    mon_in = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 32'(mon_idx), 32'hFFFF_FFFF);
                    end else begin
                        txn_t e;
                        e = exp_q.pop_front();
                        check("grant_start", 32'(mon_start), 32'(e.start));
                        check("grant_idx", 32'(mon_idx), 32'(e.idx));
                        check("grant_len", 32'(mon_len), 32'(e.len));
                        check("timeout_pulse", 32'(timeout), 32'(e.to));
                    end
                    check("gnt_zero_release", 32'(gnt), 32'h0);
                end
            end else begin
                check("spurious_timeout", 32'(timeout), 32'h0);
                if (gnt_valid) begin
                    mon_in    = 1;
                    mon_start = cyc;
                    mon_idx   = int'(gnt_idx);
                    mon_len   = 1;
                    check("gnt_onehot", 32'(gnt), 32'(16'h1 << mon_idx));
                end else begin
                    check("gnt_idle_zero", 32'(gnt), 32'h0);
                end
            end
        end
    end

    task automatic wait_grant(input string name);
        int n = 0;
        while (!gnt_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!gnt_valid) check({name, "_wait_timeout"}, 32'(gnt_valid), 32'h1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_idx", 32'(gnt_idx), 32'h0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single request, then ptr=5 makes bit 5 win over bit 0
        en  = 1'b1;
        req = 16'h0010;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h0010);
        check("single_idx", 32'(gnt_idx), 32'h4);
        idle_cycles(2);
        req = 16'h0000;
        idle_cycles(2);
        req = 16'h0021;
        wait_grant("ptr5");
        check("ptr5_idx", 32'(gnt_idx), 32'h5);
        req = 16'h0000;
        idle_cycles(2);

        // round robin between 0 and 15 with forced releases
        req = 16'h8001;
        idle_cycles(40);
        req = 16'h0000;
        idle_cycles(2);

        // wrap-around: grant 14, then 0 must win over 14
        req = 16'h4000;
        wait_grant("wrap_pre");
        idle_cycles(1);
        req = 16'h0000;
        @(negedge clk);
        req = 16'h4001;
        @(negedge clk);
        @(negedge clk);
        check("wrap_idx", 32'(gnt_idx), 32'h0);
        req = 16'h0000;
        idle_cycles(2);

        // boundary tie: request drops in the last allowed hold cycle
        req = 16'h0002;
        wait_grant("tie");
        idle_cycles(MAXH - 1);
        req = 16'h0000;
        @(negedge clk);
        check("tie_no_timeout", 32'(timeout), 32'h0);
        idle_cycles(2);

        // enable gating: current grant finishes, nothing new while en=0
        req = 16'hFFFF;
        wait_grant("en_gate");
        en = 1'b0;
        idle_cycles(MAXH + 4);
        check("en_gate_idle", 32'(gnt_valid), 32'h0);
        idle_cycles(6);
        check("en_gate_idle2", 32'(gnt_valid), 32'h0);
        en = 1'b1;
        idle_cycles(3);
        req = 16'h0000;
        idle_cycles(MAXH + 2);

        // mid-grant asynchronous reset
        req = 16'h0100;
        wait_grant("rst_mid");
        idle_cycles(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_valid", 32'(gnt_valid), 32'h0);
        check("midrst_timeout", 32'(timeout), 32'h0);
        m_busy = 0;
        m_ptr  = 0;
        m_len  = 0;
        mon_in = 0;
        req    = 16'h0101;
        #1;
        rst_n = 1'b1;
        wait_grant("post_rst");
        check("post_rst_idx", 32'(gnt_idx), 32'h0);
        req = 16'h0000;
        idle_cycles(3);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 16'h0;
                    1:       req = 16'(1 << $urandom_range(0, 15));
                    2:       req = 16'($urandom) & 16'($urandom);
                    default: req = 16'($urandom);
                endcase
            end
        end

        en  = 1'b1;
        req = 16'h0000;
        idle_cycles(MAXH + 4);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
        check("drain_idle", 32'(gnt_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
